sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port front end for the single-port `sram`: sequences a zero-fill of the whole array after reset or on command, then arbitrates read/write requests from two requesters. Round-robin arbitration, one SRAM access issued per cycle. Sits between the BDD node/unique-table engines and the `sram` instance, and drives its address, write-enable and write-data pins.

## Interface
- ADDR_WIDTH, 5: SRAM address width.
- DATA_WIDTH, 32: SRAM data width.
- DEPTH, 32: number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- i_clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_clr_start  in  1  pulse; requests a zero-fill of the array.
- i_req0 / i_req1  in  1  access request; held until the matching grant is seen.
- i_we0 / i_we1  in  1  1 = write, 0 = read; held with its request.
- i_addr0 / i_addr1  in  ADDR_WIDTH  address; held with its request.
- i_wdata0 / i_wdata1  in  DATA_WIDTH  write data; held with its request.
- o_gnt0 / o_gnt1  out  1  one-cycle pulse: the request is being issued this cycle.
- o_rvalid0 / o_rvalid1  out  1  read data valid for that requester.
- o_rdata  out  DATA_WIDTH  read data; shared by both requesters, qualified by o_rvalid0/1.
- o_busy  out  1  zero-fill in progress.
- o_clr_done  out  1  one-cycle pulse at the end of a zero-fill.
- o_mem_addr  out  ADDR_WIDTH  to the SRAM i_addr pin.
- o_mem_write  out  1  to the SRAM i_write pin.
- o_mem_wdata  out  DATA_WIDTH  to the SRAM i_data pin.
- i_mem_rdata  in  DATA_WIDTH  from the SRAM o_data pin; the SRAM registers it, so it is valid one cycle after the read command.

## Operation
- States:
  - CLEAR: fill counter drives o_mem_write=1, o_mem_addr=cnt, o_mem_wdata=0.
  - SERVE: arbitrate requests.
- Fill counter:
  - Width ADDR_WIDTH+1, so DEPTH = 2^ADDR_WIDTH is handled.
  - Counts 0..DEPTH-1, then → SERVE.
- Reset (rst_n=0) values:
  - State CLEAR, cnt=0, o_busy=1, RR pointer favours requester 0.
  - All other outputs 0.
- Entry into CLEAR:
  - CLEAR is entered automatically when reset is released.
  - It is also entered from SERVE when i_clr_start=1.
  - i_clr_start is ignored while in CLEAR; the fill does not restart.
- In CLEAR, no grants are issued. Requests stay pending and are not lost.
- SERVE arbitration (registered):
  - Requests are sampled at each rising edge.
  - The winner's addr, we and wdata are registered onto o_mem_*, and its o_gnt is high for that one following cycle.
  - With no winner: o_mem_write=0, o_mem_addr holds its value.
- Eligibility: a requester whose o_gnt is high in the current cycle is not eligible at that edge. This stops a still-held request from being re-granted.
- Round robin:
  - If both requesters are eligible, the one the pointer favours wins.
  - After each grant, the pointer favours the other requester.
  - If only one requester is eligible, it wins regardless of the pointer.
- i_clr_start in SERVE takes priority over any pending request at the same edge.
- Reads:
  - A granted read issued in cycle N gives o_rvalidk=1 in cycle N+1, with o_rdata=i_mem_rdata (combinational pass-through).
  - A read in flight when CLEAR starts still returns its data.

## Timing
- Reset release:
  - Clear writes occupy cycles 1..DEPTH after the first rising edge with rst_n=1.
  - o_busy falls and o_clr_done pulses in cycle DEPTH+1.
  - A request held from reset gets its o_gnt no earlier than cycle DEPTH+1.
- Grant latency: a request asserted before edge E (in SERVE) is granted in the cycle following E.
- Read latency: 2 cycles from the request-sampling edge to o_rvalid.
- Throughput:
  - One SRAM access per cycle when the two requesters alternate.
  - Maximum rate for a single requester: one access per 2 cycles.
- i_clr_start sampled at edge E:
  - The first clear write (addr 0) is presented in the cycle after E.
  - o_clr_done pulses DEPTH cycles later.
- Asynchronous reset asserted mid-fill or mid-read:
  - Outputs are forced immediately to their reset values.
  - Any in-flight o_rvalid is dropped.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins when both requesters are eligible, and the RR pointer is not built.
  - Undefined: round robin as described in Operation.

## Test plan
- Reset release, DEPTH=32: writes to addr 0..31 with data 0 in cycles 1..32, o_clr_done pulses in cycle 33 → then a read of every address returns 0x00000000.
- Req0 writes 0xDEADBEEF to addr 5, then reads addr 5 → o_gnt0 is 1 for one cycle per access, and o_rvalid0 is 1 with o_rdata=0xDEADBEEF one cycle after the read grant.
- Both requesters hold requests continuously → grants alternate 0,1,0,1, one per cycle. With SRAM_ARB_FIXED_PRIO_EN defined, the sequence is 0, 1, 0, 1 while requester 0 is ineligible for a cycle after each grant; requester 1 is never granted while requester 0 is eligible.
- i_clr_start at the same edge as a pending req1 write of 0x1234 to addr 3 → the fill runs first. The req1 grant follows o_clr_done, and a read of addr 3 returns 0x1234.
- req0 read granted in cycle N, with i_clr_start sampled at the edge ending cycle N → o_rvalid0 is still 1 in cycle N+1 with correct data, and the fill starts in cycle N+1.
- rst_n pulled low at clear write 10 → all outputs go to their reset values asynchronously; after release, the fill restarts at addr 0 and runs the full 32 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// Zero-fill sequencer and two-requester arbiter in front of a single-port SRAM.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) over round robin.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_clr_start,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_rvalid0,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_clr_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_END = CW'(DEPTH);

  typedef enum logic {
    CLEAR,
    SERVE
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic                  gnt0_n;
  logic                  gnt1_n;
  logic                  busy_n;
  logic                  done_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  elig0;
  logic                  elig1;
  logic                  win0;
  logic                  win1;

  // A requester granted this cycle still holds its request; skip it once.
  assign elig0 = i_req0 & ~o_gnt0;
  assign elig1 = i_req1 & ~o_gnt1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign win0 = elig0;
  assign win1 = elig1 & ~elig0;
`else
  logic ptr;

  assign win0 = elig0 & (~elig1 | ~ptr);
  assign win1 = elig1 & (~elig0 | ptr);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (gnt0_n) begin
      ptr <= 1'b1;
    end else if (gnt1_n) begin
      ptr <= 1'b0;
    end
  end
`endif

  assign o_rdata = i_mem_rdata;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    busy_n  = o_busy;
    done_n  = 1'b0;
    we_n    = 1'b0;
    addr_n  = o_mem_addr;
    wdata_n = o_mem_wdata;
    unique case (state)
      CLEAR: begin
        if (cnt == CNT_END) begin
          state_n = SERVE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          we_n    = 1'b1;
          addr_n  = cnt[ADDR_WIDTH-1:0];
          wdata_n = '0;
          cnt_n   = cnt + CW'(1);
        end
      end
      SERVE: begin
        if (i_clr_start) begin
          // Word 0 goes out on this edge, so the fill resumes at 1.
          state_n = CLEAR;
          busy_n  = 1'b1;
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = '0;
          cnt_n   = CW'(1);
        end else if (win0) begin
          gnt0_n  = 1'b1;
          we_n    = i_we0;
          addr_n  = i_addr0;
          wdata_n = i_wdata0;
        end else if (win1) begin
          gnt1_n  = 1'b1;
          we_n    = i_we1;
          addr_n  = i_addr1;
          wdata_n = i_wdata1;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR;
      cnt         <= '0;
      o_busy      <= 1'b1;
      o_clr_done  <= 1'b0;
      o_gnt0      <= 1'b0;
      o_gnt1      <= 1'b0;
      o_rvalid0   <= 1'b0;
      o_rvalid1   <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      o_busy      <= busy_n;
      o_clr_done  <= done_n;
      o_gnt0      <= gnt0_n;
      o_gnt1      <= gnt1_n;
      o_rvalid0   <= o_gnt0 & ~o_mem_write;
      o_rvalid1   <= o_gnt1 & ~o_mem_write;
      o_mem_write <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, corner sequences and a randomized
// run against a queue-based reference model with a tiny SRAM model.
module tb_sram_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clr_start = 1'b0;
  logic          req0      = 1'b0;
  logic          req1      = 1'b0;
  logic          we0       = 1'b0;
  logic          we1       = 1'b0;
  logic [AW-1:0] addr0     = '0;
  logic [AW-1:0] addr1     = '0;
  logic [DW-1:0] wdata0    = '0;
  logic [DW-1:0] wdata1    = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic          busy, clr_done, mem_write;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          fav      = 1'b0;

  typedef struct {
    int            p;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
  } vec_t;
  vec_t vt[8];

  int            q[$];
  int            it;
  logic          c_g0, c_g1, c_rd, c_rv0, c_rv1, c_w, c_busy, c_done;
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_d, c_rdv, c_rdata;
  logic          n_g0, n_g1, n_rd, n_rv0, n_rv1, n_w, n_busy, n_done;
  logic [AW-1:0] n_a;
  logic [DW-1:0] n_d, n_rdv, n_rdata;
  logic          e0, e1, pick1, s, alt_first, exp1;

  sram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .rst_n(rst_n),
    .i_clr_start(clr_start),
    .i_req0(req0),
    .i_req1(req1),
    .i_we0(we0),
    .i_we1(we1),
    .i_addr0(addr0),
    .i_addr1(addr1),
    .i_wdata0(wdata0),
    .i_wdata1(wdata1),
    .o_gnt0(gnt0),
    .o_gnt1(gnt1),
    .o_rvalid0(rvalid0),
    .o_rvalid1(rvalid1),
    .o_rdata(rdata),
    .o_busy(busy),
    .o_clr_done(clr_done),
    .o_mem_addr(mem_addr),
    .o_mem_write(mem_write),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic wait_gnt(input int p, input int max, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? gnt0 : gnt1;
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " done"}, clr_done, 0);
    chk({nm, " gnt0"}, gnt0, 0);
    chk({nm, " gnt1"}, gnt1, 0);
    chk({nm, " rvalid0"}, rvalid0, 0);
    chk({nm, " rvalid1"}, rvalid1, 0);
    chk({nm, " write"}, mem_write, 0);
    chk({nm, " addr"}, mem_addr, 0);
    chk({nm, " wdata"}, mem_wdata, 0);
  endtask

  // Cycle k of a fill: writes word k-1 for k<=DEPTH, done pulse at DEPTH+1.
  task automatic check_fill(input string nm, input int first);
    for (int k = first; k <= DEPTH + 1; k++) begin
      @(negedge clk);
      clr_start = 1'b0;
      chk({nm, " gnt0"}, gnt0, 0);
      chk({nm, " gnt1"}, gnt1, 0);
      chk({nm, " write"}, mem_write, k <= DEPTH);
      chk({nm, " busy"}, busy, k <= DEPTH);
      chk({nm, " done"}, clr_done, k > DEPTH);
      if (k <= DEPTH) begin
        chk({nm, " addr"}, mem_addr, k - 1);
        chk({nm, " wdata"}, mem_wdata, 0);
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  task automatic access(input string nm, input int p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e);
    int   lat  = 0;
    logic seen = 1'b0;
    drive(p, 1'b1, w, a, d);
    while (!seen && lat < 6) begin
      @(negedge clk);
      lat++;
      seen = (p == 0) ? gnt0 : gnt1;
    end
    chk({nm, " grant latency"}, lat, 1);
    chk({nm, " mem addr"}, mem_addr, a);
    chk({nm, " mem write"}, mem_write, w);
    if (w) chk({nm, " mem wdata"}, mem_wdata, d);
    drive(p, 1'b0, w, a, d);
    if (seen) begin
      fav = (p == 0);
      if (w) exp_mem[a] = d;
    end
    @(negedge clk);
    chk({nm, " grant pulse"}, (p == 0) ? gnt0 : gnt1, 0);
    chk({nm, " addr hold"}, mem_addr, a);
    chk({nm, " rvalid"}, (p == 0) ? rvalid0 : rvalid1, !w);
    if (!w) chk({nm, " rdata"}, rdata, e);
  endtask

  initial begin
    vt[0] = '{0, 1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0};
    vt[1] = '{0, 1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};
    vt[2] = '{1, 1'b1, 5'd31, 32'hA5A5_5A5A, 32'h0};
    vt[3] = '{0, 1'b0, 5'd31, 32'h0,         32'hA5A5_5A5A};
    vt[4] = '{1, 1'b0, 5'd5,  32'h0,         32'hDEAD_BEEF};
    vt[5] = '{1, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0};
    vt[6] = '{0, 1'b0, 5'd0,  32'h0,         32'hFFFF_FFFF};
    vt[7] = '{1, 1'b0, 5'd12, 32'h0,         32'h0};

    // Reset state, fill after release, request held across the fill.
    drive(1, 1'b1, 1'b0, 5'd7, 32'h0);
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_fill("fill after reset", 1);
    wait_gnt(1, 4, s);
    chk("held req1 grant after fill", s, 1);
    chk("held req1 grant addr", mem_addr, 7);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    fav = 1'b0;
    @(negedge clk);
    chk("held req1 rvalid", rvalid1, 1);
    chk("held req1 rvalid0 quiet", rvalid0, 0);
    chk("held req1 rdata", rdata, 0);

    for (int a = 0; a < DEPTH; a++)
      access($sformatf("zero read %0d", a), a % 2, 1'b0, AW'(a), 32'h0, 32'h0);

    for (int i = 0; i < 8; i++)
      access($sformatf("vec%0d", i), vt[i].p, vt[i].we, vt[i].a, vt[i].d, vt[i].e);

    // Both requesters held: grants alternate one per cycle.
`ifdef SRAM_ARB_FIXED_PRIO_EN
    alt_first = 1'b0;
`else
    alt_first = fav;
`endif
    drive(0, 1'b1, 1'b1, 5'd20, 32'h2020_2020);
    drive(1, 1'b1, 1'b1, 5'd21, 32'h2121_2121);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp1 = alt_first ^ i[0];
      chk($sformatf("alt gnt0 %0d", i), gnt0, !exp1);
      chk($sformatf("alt gnt1 %0d", i), gnt1, exp1);
      chk($sformatf("alt addr %0d", i), mem_addr, exp1 ? 21 : 20);
    end
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    exp_mem[20] = 32'h2020_2020;
    exp_mem[21] = 32'h2121_2121;
    fav = alt_first;
    @(negedge clk);
    access("alt readback", 0, 1'b0, 5'd21, 32'h0, 32'h2121_2121);

    // Clear beats a pending write at the same edge.
    clr_start = 1'b1;
    drive(1, 1'b1, 1'b1, 5'd3, 32'h1234);
    check_fill("fill before pending write", 1);
    wait_gnt(1, 4, s);
    chk("pending write grant", s, 1);
    chk("pending write addr", mem_addr, 3);
    chk("pending write data", mem_wdata, 32'h1234);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    fav = 1'b0;
    exp_mem[3] = 32'h1234;
    @(negedge clk);
    access("pending write readback", 0, 1'b0, 5'd3, 32'h0, 32'h1234);

    // Read in flight when a clear starts still returns data.
    access("pre-clear write", 0, 1'b1, 5'd5, 32'hCAFE_F00D, 32'h0);
    drive(0, 1'b1, 1'b0, 5'd5, 32'h0);
    wait_gnt(0, 4, s);
    chk("inflight read grant", s, 1);
    clr_start = 1'b1;
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    fav = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    chk("inflight rvalid0", rvalid0, 1);
    chk("inflight rdata", rdata, 32'hCAFE_F00D);
    chk("inflight fill write", mem_write, 1);
    chk("inflight fill addr", mem_addr, 0);
    chk("inflight busy", busy, 1);
    check_fill("fill after inflight read", 2);

    // Asynchronous reset at clear write 10.
    @(negedge clk);
    clr_start = 1'b1;
    s = 1'b0;
    for (int i = 0; i < 16 && !s; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
      s = mem_write && (mem_addr == 10);
    end
    chk("reach clear write 10", s, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset mid-fill");
    fav = 1'b0;
    @(negedge clk);
    chk_reset("reset held");
    rst_n = 1'b1;
    check_fill("fill after mid-fill reset", 1);

    // Asynchronous reset drops an in-flight read.
    drive(0, 1'b1, 1'b0, 5'd5, 32'h0);
    wait_gnt(0, 4, s);
    chk("pre-reset read grant", s, 1);
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("reset drops gnt0", gnt0, 0);
    @(negedge clk);
    chk("reset drops rvalid0", rvalid0, 0);
    rst_n = 1'b1;
    fav = 1'b0;
    check_fill("fill after read reset", 1);
    @(negedge clk);

    // Randomized run against the queue model.
    c_g0 = 0; c_g1 = 0; c_rd = 0; c_rv0 = 0; c_rv1 = 0;
    c_w = 0; c_busy = 0; c_done = 0;
    c_a = '0; c_d = '0; c_rdv = '0; c_rdata = '0;
    q.delete();
    for (int t = 0; t < 600; t++) begin
      if (!req0 || gnt0) begin
        if ($urandom_range(1, 0) == 1)
          drive(0, 1'b1, 1'($urandom_range(1, 0)),
                AW'($urandom_range(DEPTH - 1, 0)), $urandom);
        else
          drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
      end
      if (!req1 || gnt1) begin
        if ($urandom_range(1, 0) == 1)
          drive(1, 1'b1, 1'($urandom_range(1, 0)),
                AW'($urandom_range(DEPTH - 1, 0)), $urandom);
        else
          drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
      end
      clr_start = ($urandom_range(39, 0) == 0);

      n_rv0 = c_g0 & c_rd;
      n_rv1 = c_g1 & c_rd;
      n_rdata = c_rdv;
      n_g0 = 0; n_g1 = 0; n_w = 0; n_rd = 0; n_done = 0; n_busy = 0;
      n_a = c_a; n_d = c_d; n_rdv = c_rdv;
      if (q.size() > 0) begin
        it = q.pop_front();
        if (it < 0) begin
          n_done = 1;
        end else begin
          n_w = 1; n_a = AW'(it); n_d = '0; n_busy = 1;
          exp_mem[it] = '0;
        end
      end else if (clr_start) begin
        for (int i = 1; i < DEPTH; i++) q.push_back(i);
        q.push_back(-1);
        n_w = 1; n_a = '0; n_d = '0; n_busy = 1;
        exp_mem[0] = '0;
      end else begin
        e0 = req0 && !c_g0;
        e1 = req1 && !c_g1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        pick1 = e1 && !e0;
`else
        pick1 = e1 && (!e0 || fav);
`endif
        if (pick1) begin
          n_g1 = 1; n_w = we1; n_a = addr1; n_d = wdata1; fav = 1'b0;
          if (we1) exp_mem[addr1] = wdata1;
          else begin n_rd = 1; n_rdv = exp_mem[addr1]; end
        end else if (e0) begin
          n_g0 = 1; n_w = we0; n_a = addr0; n_d = wdata0; fav = 1'b1;
          if (we0) exp_mem[addr0] = wdata0;
          else begin n_rd = 1; n_rdv = exp_mem[addr0]; end
        end
      end

      @(negedge clk);
      c_g0 = n_g0; c_g1 = n_g1; c_w = n_w; c_a = n_a; c_d = n_d;
      c_rd = n_rd; c_rdv = n_rdv; c_rv0 = n_rv0; c_rv1 = n_rv1;
      c_rdata = n_rdata; c_busy = n_busy; c_done = n_done;
      chk("rnd gnt0", gnt0, c_g0);
      chk("rnd gnt1", gnt1, c_g1);
      chk("rnd write", mem_write, c_w);
      chk("rnd busy", busy, c_busy);
      chk("rnd done", clr_done, c_done);
      chk("rnd rvalid0", rvalid0, c_rv0);
      chk("rnd rvalid1", rvalid1, c_rv1);
      if (c_rv0 || c_rv1) chk("rnd rdata", rdata, c_rdata);
      if (c_w || c_g0 || c_g1) chk("rnd addr", mem_addr, c_a);
      if (c_w) chk("rnd wdata", mem_wdata, c_d);
    end
    drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
    clr_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
